spirw_master: RTL and testbench

SPIRW_MASTER -- requirements
Module: spirw_master

---
 rtl/spirw_pkg.sv | 23 ++
 rtl/spirw_master_shift.sv | 85 ++++++++
 rtl/spirw_master.sv | 221 ++++++++++++++++++++++
 tb/tb_spirw_master.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spirw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spirw_pkg
// Description : Command codes and frame-state enumeration shared by the
//               spirw master and slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spirw_pkg;

  localparam logic [7:0] c_cmd_write = 8'h00;
  localparam logic [7:0] c_cmd_read  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5
  } spirw_state_e;

endpackage
`default_nettype wire

// File: rtl/spirw_master_shift.sv
`default_nettype none
// ============================================================================
// Module      : spirw_master_shift
// Description : 8-bit SPI mode-0 shifter with built-in sclk divider. A load
//               starts a byte; byte_done marks the cycle whose closing edge is
//               the 8th falling sclk edge, so a new load there gives no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module spirw_master_shift
  import spirw_pkg::*;
#(
  parameter int c_sclk_div = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       byte_done_o,
  output logic       rx_done_o,
  output logic [7:0] rx_byte_o
);

  localparam int c_hc_w = (c_sclk_div > 1) ? $clog2(c_sclk_div) : 1;
  localparam logic [c_hc_w-1:0] c_hc_last = c_hc_w'(c_sclk_div - 1);

  logic              active_q;
  logic [c_hc_w-1:0] hc_q;
  logic [3:0]        half_q;
  logic              sclk_q;
  logic [7:0]        tx_q;
  logic [7:0]        rx_q;

  logic tick;
  logic rise;
  logic fall;

  assign tick        = active_q && (hc_q == c_hc_last);
  assign rise        = tick && !half_q[0];
  assign fall        = tick && half_q[0];
  assign byte_done_o = fall && (half_q == 4'd15);
  assign rx_done_o   = rise && (half_q == 4'd14);
  assign rx_byte_o   = {rx_q[6:0], miso_i};
  assign sclk_o      = sclk_q;
  assign mosi_o      = tx_q[7];

  // Half-period divider, sclk generation, mosi shift on fall, miso capture on rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      hc_q     <= '0;
      half_q   <= 4'd0;
      sclk_q   <= 1'b0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
    end else if (load_i) begin
      active_q <= 1'b1;
      hc_q     <= '0;
      half_q   <= 4'd0;
      sclk_q   <= 1'b0;
      tx_q     <= load_data_i;
    end else if (active_q) begin
      if (tick) begin
        hc_q   <= '0;
        half_q <= half_q + 4'd1;
        if (rise) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          tx_q   <= {tx_q[6:0], 1'b0};
          if (half_q == 4'd15) begin
            active_q <= 1'b0;
          end
        end
      end else begin
        hc_q <= hc_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spirw_master.sv
`default_nettype none
// ============================================================================
// Module      : spirw_master
// Description : SPI mode-0 read/write master. Frame = command byte, address
//               bytes (MSB first), a dummy byte on reads, then len data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spirw_master
  import spirw_pkg::*;
#(
  parameter int c_addr_bits = 32,
  parameter int c_sclk_div  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rw,
  input  logic [c_addr_bits-1:0] addr,
  input  logic [15:0]            len,
  input  logic [7:0]             wr_data,
  output logic                   wr_next,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   csn,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int          c_addr_bytes = c_addr_bits / 8;
  localparam logic [1:0]  c_ab_last    = 2'(c_addr_bytes - 1);
  localparam logic [15:0] c_hold_init  = 16'(c_sclk_div - 1);
  localparam logic [15:0] c_gap_init   = 16'(2 * c_sclk_div - 1);

  spirw_state_e           state_q;
  logic                   rw_q;
  logic [c_addr_bits-1:0] addr_q;
  logic [15:0]            len_q;
  logic [15:0]            cnt_q;
  logic [1:0]             ab_q;
  logic [15:0]            hold_q;
  logic [15:0]            gap_q;
  logic                   csn_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_valid_q;
  logic [7:0]             rd_data_q;

  logic       accept;
  logic       sh_load;
  logic [7:0] sh_data;
  logic       byte_done;
  logic       rx_done;
  logic [7:0] rx_byte;

  spirw_master_shift #(
    .c_sclk_div (c_sclk_div)
  ) u_shift (
    .clk         (clk),
    .reset       (reset),
    .load_i      (sh_load),
    .load_data_i (sh_data),
    .miso_i      (miso),
    .sclk_o      (sclk),
    .mosi_o      (mosi),
    .byte_done_o (byte_done),
    .rx_done_o   (rx_done),
    .rx_byte_o   (rx_byte)
  );

  // Chooses the next byte for the shifter; loads coincide with byte_done so
  // bytes run back to back. wr_next marks the edge that consumes wr_data.
  always_comb begin
    accept  = (state_q == ST_IDLE) && start && (gap_q == 16'd0);
    sh_load = 1'b0;
    sh_data = 8'h00;
    wr_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sh_load = accept;
        sh_data = rw ? c_cmd_read : c_cmd_write;
      end
      ST_CMD: begin
        sh_load = byte_done;
        sh_data = addr_q[c_addr_bits-1 -: 8];
      end
      ST_ADDR: begin
        if (ab_q != 2'd0) begin
          sh_load = byte_done;
          sh_data = addr_q[c_addr_bits-1 -: 8];
        end else if (rw_q) begin
          sh_load = byte_done;
        end else if (len_q != 16'd0) begin
          sh_load = byte_done;
          sh_data = wr_data;
          wr_next = byte_done;
        end
      end
      ST_DUMMY: begin
        sh_load = byte_done && (len_q != 16'd0);
      end
      ST_DATA: begin
        if (cnt_q != 16'd0) begin
          sh_load = byte_done;
          if (!rw_q) begin
            sh_data = wr_data;
            wr_next = byte_done;
          end
        end
      end
      default: ;
    endcase
  end

  // Frame sequencing, byte/hold/gap counters and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      ab_q       <= 2'd0;
      hold_q     <= 16'd0;
      gap_q      <= 16'd0;
      csn_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      if (rx_done && (state_q == ST_DATA) && rw_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rx_byte;
      end
      case (state_q)
        ST_IDLE: begin
          if (gap_q != 16'd0) begin
            gap_q <= gap_q - 16'd1;
          end
          if (accept) begin
            rw_q    <= rw;
            addr_q  <= addr;
            len_q   <= len;
            csn_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            ab_q    <= c_ab_last;
            addr_q  <= addr_q << 8;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            if (ab_q != 2'd0) begin
              ab_q   <= ab_q - 2'd1;
              addr_q <= addr_q << 8;
            end else if (rw_q) begin
              state_q <= ST_DUMMY;
            end else if (len_q != 16'd0) begin
              cnt_q   <= len_q - 16'd1;
              state_q <= ST_DATA;
            end else begin
              hold_q  <= c_hold_init;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_DUMMY: begin
          if (byte_done) begin
            if (len_q != 16'd0) begin
              cnt_q   <= len_q - 16'd1;
              state_q <= ST_DATA;
            end else begin
              hold_q  <= c_hold_init;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            if (cnt_q != 16'd0) begin
              cnt_q <= cnt_q - 16'd1;
            end else begin
              hold_q  <= c_hold_init;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == 16'd0) begin
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gap_q   <= c_gap_init;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign csn      = csn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spirw_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spirw_master
// Description : Self-checking bench for spirw_master. Three instances with
//               different divider/address widths share one muxed monitor and
//               slave model; expected frames are queued at start and popped
//               as bytes appear on mosi / rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spirw_master;

  localparam int c_div_tab [3] = '{2, 1, 3};
  localparam int c_ab_tab  [3] = '{32, 16, 8};

  typedef struct {
    int          inst;
    logic        rw;
    logic [31:0] addr;
    logic [15:0] len;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start   [3];
  logic        rw      [3];
  logic [31:0] addr    [3];
  logic [15:0] len     [3];
  logic [7:0]  wr_data [3];
  logic        wr_next [3];
  logic [7:0]  rd_data [3];
  logic        rd_valid[3];
  logic        busy    [3];
  logic        done    [3];
  logic        csn     [3];
  logic        sclk    [3];
  logic        mosi    [3];
  logic        miso    [3];

  int sel = 0;
  int d_cur;
  logic csn_w, sclk_w, mosi_w, busy_w, done_w, wr_next_w, rd_valid_w, miso_w;
  logic [7:0] rd_data_w;

  assign d_cur      = c_div_tab[sel];
  assign csn_w      = csn[sel];
  assign sclk_w     = sclk[sel];
  assign mosi_w     = mosi[sel];
  assign busy_w     = busy[sel];
  assign done_w     = done[sel];
  assign wr_next_w  = wr_next[sel];
  assign rd_valid_w = rd_valid[sel];
  assign rd_data_w  = rd_data[sel];

  logic [7:0] wq [4];
  int         wr_idx = 0;
  logic [7:0] sb [16];
  logic [7:0] sb_byte;
  logic [7:0] exp_mosi [$];
  logic [7:0] exp_rd   [$];

  int n_chk = 0;
  int n_pass = 0;

  // Monitor state
  logic        prev_csn = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] rises = 16'd0;
  logic [7:0]  mo_sr = 8'h00;
  int run = 0, lowcnt = 0, nbytes = 0, tviol = 0, wrn = 0, rdv = 0, dn = 0, frames = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int c_ab = c_ab_tab[gi];
    spirw_master #(
      .c_addr_bits (c_ab),
      .c_sclk_div  (c_div_tab[gi])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[gi]),
      .rw       (rw[gi]),
      .addr     (addr[gi][c_ab-1:0]),
      .len      (len[gi]),
      .wr_data  (wr_data[gi]),
      .wr_next  (wr_next[gi]),
      .rd_data  (rd_data[gi]),
      .rd_valid (rd_valid[gi]),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .csn      (csn[gi]),
      .sclk     (sclk[gi]),
      .mosi     (mosi[gi]),
      .miso     (miso[gi])
    );
    assign miso[gi]    = (sel == gi) ? miso_w : 1'b0;
    assign wr_data[gi] = (wr_idx < 4) ? wq[wr_idx] : 8'h00;
  end

  always #5 clk = ~clk;

  // Slave model: bit index within frame = number of rises seen so far
  always_comb begin
    sb_byte = 8'h00;
    miso_w  = 1'b0;
    if (rises < 16'd128) begin
      sb_byte = sb[rises[6:3]];
      miso_w  = sb_byte[3'd7 - rises[2:0]];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_mosi(input logic [7:0] b);
    if (exp_mosi.size() == 0) check("mosi_extra_byte", {24'd0, b}, 32'hFFFF_FFFF);
    else check("mosi_byte", {24'd0, b}, {24'd0, exp_mosi.pop_front()});
  endtask

  task automatic chk_rd(input logic [7:0] b);
    if (exp_rd.size() == 0) check("rd_extra_byte", {24'd0, b}, 32'hFFFF_FFFF);
    else check("rd_data", {24'd0, b}, {24'd0, exp_rd.pop_front()});
  endtask

  // Frame monitor: captures mosi on rises, checks sclk high/low runs and hold
  always @(negedge clk) begin
    prev_csn  <= csn_w;
    prev_sclk <= sclk_w;
    if (wr_next_w) wrn <= wrn + 1;
    if (done_w) dn <= dn + 1;
    if (rd_valid_w) begin
      rdv <= rdv + 1;
      chk_rd(rd_data_w);
    end
    if (!csn_w) begin
      if (prev_csn) begin
        frames <= frames + 1;
        rises  <= 16'd0;
        run    <= 1;
        lowcnt <= 1;
        nbytes <= 0;
        tviol  <= (sclk_w ? 1 : 0);
        wrn    <= 0;
        dn     <= 0;
        rdv    <= 0;
      end else begin
        lowcnt <= lowcnt + 1;
        if (sclk_w != prev_sclk) begin
          if (run != d_cur) tviol <= tviol + 1;
          run <= 1;
          if (sclk_w) begin
            rises <= rises + 16'd1;
            mo_sr <= {mo_sr[6:0], mosi_w};
            if (rises[2:0] == 3'd7) begin
              nbytes <= nbytes + 1;
              chk_mosi({mo_sr[6:0], mosi_w});
            end
          end
        end else begin
          run <= run + 1;
        end
      end
    end else begin
      if (sclk_w) tviol <= tviol + 1;
      else if (!prev_csn && rises != 16'd0 && run != d_cur) tviol <= tviol + 1;
    end
  end

  // Write-data feeder: advance to the next byte right after each load edge
  initial begin
    forever begin
      @(negedge clk);
      if (csn_w) wr_idx = 0;
      else if (wr_next_w) begin
        @(posedge clk);
        #1;
        wr_idx = wr_idx + 1;
      end
    end
  end

  task automatic prepare(input vec_t v, output int n);
    int ab, hdr;
    logic [31:0] a;
    logic [7:0] dk;
    exp_mosi.delete();
    exp_rd.delete();
    for (int i = 0; i < 16; i++) sb[i] = 8'h00;
    for (int i = 0; i < 4; i++) wq[i] = 8'h00;
    ab = c_ab_tab[v.inst];
    exp_mosi.push_back(v.rw ? 8'h01 : 8'h00);
    a = v.addr << (32 - ab);
    for (int i = 0; i < ab / 8; i++) begin
      exp_mosi.push_back(a[31:24]);
      a = a << 8;
    end
    if (v.rw) exp_mosi.push_back(8'h00);
    hdr = exp_mosi.size();
    for (int k = 0; k < int'(v.len); k++) begin
      dk = (k == 0) ? v.d0 : (k == 1) ? v.d1 : v.d2;
      if (v.rw) begin
        exp_mosi.push_back(8'h00);
        exp_rd.push_back(dk);
        sb[hdr + k] = dk;
      end else begin
        exp_mosi.push_back(dk);
        wq[k] = dk;
      end
    end
    n = exp_mosi.size();
  endtask

  task automatic run_vec(input vec_t v, input bit poke, input bit rel_rst);
    int n, d, f0;
    bit got;
    d   = c_div_tab[v.inst];
    sel = v.inst;
    prepare(v, n);
    f0 = frames;
    @(negedge clk);
    if (rel_rst) reset = 1'b0;
    start[sel] = 1'b1;
    rw[sel]    = v.rw;
    addr[sel]  = v.addr;
    len[sel]   = v.len;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    rw[sel]    = ~v.rw;
    addr[sel]  = ~v.addr;
    len[sel]   = 16'd5;
    check("csn_low_after_start", {31'd0, csn_w}, 32'd0);
    check("busy_after_start", {31'd0, busy_w}, 32'd1);
    got = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (poke && c == 40) start[sel] = 1'b1;
      if (poke && c == 41) start[sel] = 1'b0;
      if (done_w) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("csn_high_at_done", {31'd0, csn_w}, 32'd1);
    check("busy_clear_at_done", {31'd0, busy_w}, 32'd0);
    if (poke) begin
      start[sel] = 1'b1;
      repeat (2 * d - 1) @(negedge clk);
      start[sel] = 1'b0;
    end
    repeat (2 * d + 4) @(negedge clk);
    check("frames", frames - f0, 32'd1);
    check("bytes_in_frame", nbytes, n);
    check("mosi_bytes_missing", exp_mosi.size(), 32'd0);
    check("rd_bytes_missing", exp_rd.size(), 32'd0);
    check("wr_next_pulses", wrn, v.rw ? 32'd0 : {16'd0, v.len});
    check("rd_valid_pulses", rdv, v.rw ? {16'd0, v.len} : 32'd0);
    check("done_pulses", dn, 32'd1);
    check("csn_low_cycles", lowcnt, n * 16 * d + d);
    check("sclk_timing", tviol, 32'd0);
  endtask

  vec_t vt [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    vt[0] = '{0, 1'b0, 32'h0000_0100, 16'd2, 8'hA5, 8'h5A, 8'h00};
    vt[1] = '{0, 1'b1, 32'hFF00_0000, 16'd3, 8'h11, 8'h22, 8'h33};
    vt[2] = '{0, 1'b0, 32'h1234_5678, 16'd0, 8'h00, 8'h00, 8'h00};
    vt[3] = '{0, 1'b1, 32'h0000_ABCD, 16'd0, 8'h00, 8'h00, 8'h00};
    vt[4] = '{1, 1'b0, 32'h0000_BEEF, 16'd1, 8'hC3, 8'h00, 8'h00};
    vt[5] = '{2, 1'b0, 32'h0000_007E, 16'd1, 8'h3C, 8'h00, 8'h00};
    vt[6] = '{2, 1'b1, 32'h0000_0042, 16'd2, 8'h96, 8'h69, 8'h00};
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      rw[i]    = 1'b0;
      addr[i]  = 32'd0;
      len[i]   = 16'd0;
    end
    for (int i = 0; i < 4; i++) wq[i] = 8'h00;
    for (int i = 0; i < 16; i++) sb[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_csn", {31'd0, csn[0]}, 32'd1);
    check("rst_sclk", {31'd0, sclk[0]}, 32'd0);
    check("rst_mosi", {31'd0, mosi[0]}, 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_done", {31'd0, done[0]}, 32'd0);
    check("rst_wr_next", {31'd0, wr_next[0]}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid[0]}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data[0]}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], 1'b0, 1'b0);

    // Starts while busy and inside the csn-high gap are ignored
    run_vec(vt[0], 1'b1, 1'b0);

    // Asynchronous reset in the 3rd address byte, then restart on first edge
    sel = 0;
    begin
      int n;
      prepare(vt[0], n);
    end
    @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h0000_0100; len[0] = 16'd2;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rises == 16'd28) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_addr_byte3", {31'd0, reached}, 32'd1);
    check("mid_frame_csn_low", {31'd0, csn[0]}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_csn", {31'd0, csn[0]}, 32'd1);
    check("async_rst_sclk", {31'd0, sclk[0]}, 32'd0);
    check("async_rst_mosi", {31'd0, mosi[0]}, 32'd0);
    check("async_rst_busy", {31'd0, busy[0]}, 32'd0);
    exp_mosi.delete();
    exp_rd.delete();
    repeat (2) @(negedge clk);
    run_vec(vt[1], 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
